// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//   Instruction-fetch stage of the 5-stage pipeline. Owns the program counter,
//   presents it to the instruction memory, and captures the returned
//   instruction together with its PC into the IF/ID pipeline register.
//
// Parameters
//   PC_WIDTH  program-counter / address width in bits
//   RESET_PC  PC loaded on reset
//   PC_STEP   sequential PC increment in bytes
//
// Ports
//   clk               clock, rising edge
//   reset             synchronous active-high reset
//   stall             hazard-unit hold: PC and IF/ID freeze
//   branch_taken      redirect: PC loads branch_target, IF/ID is flushed
//   branch_target     redirect destination byte address (used unmasked)
//   inst_address      instruction-memory address, straight from the PC register
//   instruction_in    combinational instruction-memory read data
//   if_id_pc          PC of the instruction held in IF/ID
//   if_id_instruction instruction held in IF/ID (NOP when a bubble)
//   if_id_valid       IF/ID holds a real instruction
//   bubble_count      IF/ID bubble-cycle counter
//
// Build option
//   IF_BUBBLE_COUNT_EN  when defined, bubble_count counts redirect bubbles and
//                       stall cycles with an empty IF/ID, saturating. When
//                       undefined, bubble_count is tied to zero.
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter int unsigned           PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
  parameter int unsigned           PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] inst_address,
  input  logic [31:0]         instruction_in,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]         if_id_instruction,
  output logic                if_id_valid,
  output logic [31:0]         bubble_count
);

  // add x0,x0,x0: a bubble always carries this so decode needs no valid gating
  localparam logic [31:0]         NOP_INSTR = 32'h00000033;
  localparam logic [PC_WIDTH-1:0] PC_INC    = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0] pc_p0;
  logic [PC_WIDTH-1:0] pc_p1;
  logic [31:0]         instr_p1;
  logic                vld_p1;

  // ---- stage p0: program counter ----
  // Priority: reset > redirect > stall > sequential. A redirect overrides a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (branch_taken) begin
      pc_p0 <= branch_target;
    end else if (!stall) begin
      pc_p0 <= pc_p0 + PC_INC;
    end
  end

  assign inst_address = pc_p0;

  // ---- stage p1: IF/ID register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p1    <= '0;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (branch_taken) begin
      pc_p1    <= '0;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      pc_p1    <= pc_p0;
      instr_p1 <= instruction_in;
      vld_p1   <= 1'b1;
    end
  end

  assign if_id_pc          = pc_p1;
  assign if_id_instruction = instr_p1;
  assign if_id_valid       = vld_p1;

`ifdef IF_BUBBLE_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] bubble_cnt_p1;
  logic        bubble_evt;

  // A redirect loads a bubble; a stall with an empty IF/ID keeps one in place.
  // Both together still count as a single bubble cycle.
  assign bubble_evt = branch_taken | (stall & ~vld_p1);

  // ---- stage p1: bubble counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_p1 <= '0;
    end else if (bubble_evt) begin
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign bubble_count = bubble_cnt_p1;
`else
  assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage
//   Directed bench for instruction_fetch_stage. A driver applies one input
//   vector per cycle and queues the hand-computed post-edge outputs; a monitor
//   pops and compares each cycle. A combinational instruction-memory model
//   answers inst_address.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] inst_address;
  logic [31:0] instruction_in;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [31:0] bubble_count;

  int checks = 0;
  int errors = 0;

`ifdef IF_BUBBLE_COUNT_EN
  localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CNT_MASK = 32'h0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] ifpc;
    logic [31:0] inst;
    logic        vld;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  instruction_fetch_stage #(
    .PC_WIDTH(64),
    .RESET_PC(64'h0),
    .PC_STEP (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .inst_address     (inst_address),
    .instruction_in   (instruction_in),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .bubble_count     (bubble_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h003100B3;
      64'd4:   return 32'h00028663;
      64'd8:   return 32'h00A00093;
      64'd12:  return 32'h00B00113;
      64'd16:  return 32'h002081B3;
      64'd20:  return 32'h40208233;
      64'd24:  return 32'h0041A2B3;
      64'd28:  return 32'h00000033;
      default: return 32'h00000013;
    endcase
  endfunction

  always_comb instruction_in = imem(inst_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle after the
  // rising edge that the popped expectation describes.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("inst_address",      inst_address,             e.pc);
      chk("if_id_pc",          if_id_pc,                 e.ifpc);
      chk("if_id_instruction", {32'h0, if_id_instruction}, {32'h0, e.inst});
      chk("if_id_valid",       {63'h0, if_id_valid},     {63'h0, e.vld});
      chk("bubble_count",      {32'h0, bubble_count},    {32'h0, e.cnt});
    end
  end

  // One vector: inputs for the next rising edge, and the outputs expected after it.
  task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t,
                      input logic [63:0] pc, input logic [63:0] ipc,
                      input logic [31:0] ins, input logic v, input logic [31:0] c);
    exp_t e;
    @(negedge clk);
    #1;
    reset         = r;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    e.pc   = pc;
    e.ifpc = ipc;
    e.inst = ins;
    e.vld  = v;
    e.cnt  = c & CNT_MASK;
    sb.push_back(e);
  endtask

  localparam logic [31:0] NOP = 32'h00000033;

  initial begin
    //    rst  stl  br   target                 pc                     if_pc                  instr          v     cnt
    step(1'b1,1'b0,1'b0,64'd0,                  64'd0,                 64'd0,                 NOP,           1'b0, 32'd0);
    // free run: inst_address 4..32, IF/ID follows one cycle behind
    step(1'b0,1'b0,1'b0,64'd0,                  64'd4,                 64'd0,                 32'h003100B3,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd8,                 64'd4,                 32'h00028663,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd12,                64'd8,                 32'h00A00093,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd16,                64'd12,                32'h00B00113,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd20,                64'd16,                32'h002081B3,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd24,                64'd20,                32'h40208233,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd28,                64'd24,                32'h0041A2B3,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd32,                64'd28,                32'h00000033,  1'b1, 32'd0);
    // mid-stream reset with IF/ID valid; concurrent redirect and stall are discarded
    step(1'b1,1'b1,1'b1,64'd100,                64'd0,                 64'd0,                 NOP,           1'b0, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd4,                 64'd0,                 32'h003100B3,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd8,                 64'd4,                 32'h00028663,  1'b1, 32'd0);
    // stall 3 cycles at pc=8
    step(1'b0,1'b1,1'b0,64'd0,                  64'd8,                 64'd4,                 32'h00028663,  1'b1, 32'd0);
    step(1'b0,1'b1,1'b0,64'd0,                  64'd8,                 64'd4,                 32'h00028663,  1'b1, 32'd0);
    step(1'b0,1'b1,1'b0,64'd0,                  64'd8,                 64'd4,                 32'h00028663,  1'b1, 32'd0);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd12,                64'd8,                 32'h00A00093,  1'b1, 32'd0);
    // redirect to 28 while pc=12
    step(1'b0,1'b0,1'b1,64'd28,                 64'd28,                64'd0,                 NOP,           1'b0, 32'd1);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd32,                64'd28,                32'h00000033,  1'b1, 32'd1);
    // stall and redirect together: redirect wins
    step(1'b0,1'b1,1'b1,64'd8,                  64'd8,                 64'd0,                 NOP,           1'b0, 32'd2);
    // stall with an empty IF/ID counts as a bubble cycle
    step(1'b0,1'b1,1'b0,64'd0,                  64'd8,                 64'd0,                 NOP,           1'b0, 32'd3);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd12,                64'd8,                 32'h00A00093,  1'b1, 32'd3);
    // PC wrap at the top of the address space
    step(1'b0,1'b0,1'b1,64'hFFFF_FFFF_FFFF_FFFC,64'hFFFF_FFFF_FFFF_FFFC,64'd0,                 NOP,           1'b0, 32'd4);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd0,                 64'hFFFF_FFFF_FFFF_FFFC,32'h00000013,  1'b1, 32'd4);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd4,                 64'd0,                 32'h003100B3,  1'b1, 32'd4);
    // misaligned target is used unmasked
    step(1'b0,1'b0,1'b1,64'd2,                  64'd2,                 64'd0,                 NOP,           1'b0, 32'd5);
    step(1'b0,1'b0,1'b0,64'd0,                  64'd6,                 64'd2,                 32'h00000013,  1'b1, 32'd5);
    // final reset clears the counter
    step(1'b1,1'b0,1'b0,64'd0,                  64'd0,                 64'd0,                 NOP,           1'b0, 32'd0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction-fetch (IF) stage of the 5-stage pipelined processor: owns the program counter, drives the instruction memory's byte address, and captures the returned 32-bit instruction with its PC into the IF/ID pipeline register. It sits upstream of the instruction memory and the decode stage. It accepts a stall from the hazard unit and a taken-branch redirect, with flush, from the branch-resolution stage.

## Interface
- `PC_WIDTH`, 64, program-counter and address width in bits.
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `PC_STEP`, 4, sequential PC increment in bytes.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard-unit hold: freezes the PC and IF/ID.
- `branch_taken`  in  1  redirect request: the PC loads `branch_target` and IF/ID is flushed.
- `branch_target`  in  PC_WIDTH  redirect destination, a byte address.
- `inst_address`  out  PC_WIDTH  address to instruction memory; always equals the PC register.
- `instruction_in`  in  32  combinational instruction-memory read data for `inst_address`.
- `if_id_pc`  out  PC_WIDTH  PC of the instruction held in IF/ID.
- `if_id_instruction`  out  32  instruction held in IF/ID.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 means a bubble.
- `bubble_count`  out  32  IF/ID bubble-cycle counter (see Configuration).

## Operation
- State: `pc` register; IF/ID register {`if_id_pc`, `if_id_instruction`, `if_id_valid`}; optional `bubble_count`.
- `inst_address = pc`, purely from the register. There is no combinational path from any input to `inst_address`.
- Next-state priority, evaluated each rising edge, highest first:
  - `reset`: pc←RESET_PC; if_id_pc←0; if_id_instruction←32'h00000033 (add x0,x0,x0 NOP); if_id_valid←0; bubble_count←0.
  - `branch_taken`: pc←branch_target; if_id_instruction←32'h00000033; if_id_valid←0; if_id_pc←0. This applies even when `stall`=1; a redirect overrides a stall.
  - `stall`: pc and the whole IF/ID register hold.
  - Otherwise: pc←pc+PC_STEP; if_id_pc←pc; if_id_instruction←instruction_in; if_id_valid←1.
- PC arithmetic: unsigned, modulo 2^PC_WIDTH. Incrementing from 2^64−4 wraps to 0 with no flag.
- `branch_target` is used as given. Misalignment is not checked; bits [1:0] are not masked.
- A bubble always carries the NOP encoding, so downstream decode needs no valid gating for correctness.
- Reset asserted mid-operation discards any in-flight IF/ID contents and pending redirect in that cycle.

## Timing
- Fetch latency: an instruction at address A reaches the IF/ID outputs at the first edge after the cycle in which `pc`==A and `stall`=0 and `branch_taken`=0.
- Redirect penalty: the edge sampling `branch_taken`=1 produces one bubble in IF/ID. The target instruction appears in IF/ID one edge later, provided no stall occurs.
- Stall held for N cycles: the PC and IF/ID hold for exactly N edges. Fetch resumes on the first edge with `stall`=0.
- Throughput: one instruction per cycle when neither stall nor redirect is active.
- Output values after reset release: `inst_address`=RESET_PC, `if_id_valid`=0, `if_id_instruction`=32'h00000033, `if_id_pc`=0, `bubble_count`=0.

## Configuration
- `IF_BUBBLE_COUNT_EN` defined:
  - `bubble_count` increments on every edge at which IF/ID is loaded with a bubble because of a redirect.
  - It also increments on every edge where `stall`=1 while `if_id_valid`=0.
  - The count saturates at 32'hFFFFFFFF and clears on reset.
- `IF_BUBBLE_COUNT_EN` undefined: no counter logic exists, and `bubble_count` is tied to 32'h0. The port list is the same in both builds.

## Test plan
- Reset, then 8 free-running cycles against the combinational instruction memory model:
  - `inst_address` steps 0,4,8,…,28.
  - The cycle after `pc`=0, IF/ID reads if_id_pc=0, if_id_instruction=32'h003100B3, if_id_valid=1.
- `stall`=1 for 3 cycles with pc=8: pc stays 8 and IF/ID stays {4, 32'h00028663} for exactly 3 edges; fetch resumes at 8.
- `branch_taken`=1 with branch_target=28 while pc=12:
  - Next edge: pc=28 and IF/ID holds the bubble {0, 32'h00000033, valid 0}.
  - Following edge: IF/ID holds {28, 32'h00000033, valid 1}.
- `stall`=1 and `branch_taken`=1 on the same edge: the redirect wins. pc←target, IF/ID is flushed, and `bubble_count` increments by 1 when `IF_BUBBLE_COUNT_EN` is defined.
- Force pc=64'hFFFFFFFFFFFFFFFC via redirect, then run free: the next pc is 0, with no X on any output.
- `reset` pulsed for 1 cycle mid-stream with IF/ID valid: the next edge gives pc=0, if_id_valid=0, bubble_count=0.
